// File: rtl/lead_bits_normalizer_pkg.sv
// lead_bits_normalizer_pkg: FSM state encoding and exponent-range derivation
// shared by the normalizer and its rounder.
package lead_bits_normalizer_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    // Largest exponent: the number of positions the significand window can
    // slide down the magnitude.
    function automatic int calc_maxexp(input int mag_w, input int sig_w);
        return mag_w - sig_w;
    endfunction

endpackage

// File: rtl/lead_bits_normalizer_sig_rounder.sv
// sig_rounder: round-half-up of a normalized significand with exponent bump
// and saturation at the top exponent.
//   sig/exp/fb          : pre-round significand, exponent, first dropped bit
//   rnd_sig/rnd_exp/sat : rounded significand, adjusted exponent, saturation flag
module sig_rounder #(
    parameter int SIG_W    = 4,
    parameter int EXP_W    = 3,
    parameter int MAXEXP   = 7,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [EXP_W-1:0] exp,
    input  logic             fb,
    output logic [SIG_W-1:0] rnd_sig,
    output logic [EXP_W-1:0] rnd_exp,
    output logic             sat
);
    logic [SIG_W:0] sum;
    logic           carry;
    logic           at_max;
    assign sum    = {1'b0, sig} + {{SIG_W{1'b0}}, ROUND_EN && fb};
    assign carry  = sum[SIG_W];
    assign at_max = exp == EXP_W'(MAXEXP);
    // A carry renormalizes to 100..0 one exponent up, unless the exponent is
    // already at the top, where the value clamps to all ones.
    assign rnd_sig = !carry ? sum[SIG_W-1:0] : at_max ? '1 : {1'b1, {(SIG_W-1){1'b0}}};
    assign rnd_exp = carry && !at_max ? exp + 1'b1 : exp;
    assign sat     = carry && at_max;
endmodule

// File: rtl/lead_bits_normalizer.sv
// lead_bits_normalizer: sequential leading-zero normalizer producing a
// rounded SIG_W-bit significand and EXP_W-bit exponent from a MAG_W magnitude.
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready/in_mag: input handshake and magnitude
//   out_valid/out_ready     : output handshake
//   out_sig/out_exp         : rounded significand and exponent
//   out_fb                  : first dropped bit before rounding
//   out_sat                 : rounding saturated at the top exponent
module lead_bits_normalizer
    import lead_bits_normalizer_pkg::*;
#(
    parameter int MAG_W    = 11,
    parameter int SIG_W    = 4,
    parameter int EXP_W    = 3,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [MAG_W-1:0] in_mag,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_fb,
    output logic             out_sat
);
    localparam int MAXEXP = calc_maxexp(MAG_W, SIG_W);
    localparam logic [EXP_W-1:0] MAXEXP_E = EXP_W'(MAXEXP);

    if ((1 << EXP_W) - 1 < MAXEXP) begin : g_exp_too_narrow
        $error("EXP_W cannot represent MAXEXP");
    end

    state_t           state, next;
    logic [MAG_W-1:0] shreg;
    logic [EXP_W-1:0] count;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] pre_sig;
    logic             fb;
    logic             shift_done;
    logic [SIG_W-1:0] rnd_sig;
    logic [EXP_W-1:0] rnd_exp;
    logic             sat;

    // Shifting stops once the MSB is set or the exponent bottoms out; in the
    // latter (denormal) case the window holds in_mag[SIG_W-1:0].
    assign shift_done = shreg[MAG_W-1] || count == MAXEXP_E;
    assign exp        = MAXEXP_E - count;
    assign pre_sig    = shreg[MAG_W-1 -: SIG_W];
    assign fb         = exp != '0 && shreg[MAG_W-SIG_W-1];
    assign in_ready   = state == IDLE;

    sig_rounder #(
        .SIG_W   (SIG_W),
        .EXP_W   (EXP_W),
        .MAXEXP  (MAXEXP),
        .ROUND_EN(ROUND_EN)
    ) u_rounder (
        .sig    (pre_sig),
        .exp    (exp),
        .fb     (fb),
        .rnd_sig(rnd_sig),
        .rnd_exp(rnd_exp),
        .sat    (sat)
    );

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? SHIFT : IDLE;
            SHIFT:   next = shift_done ? ROUND : SHIFT;
            ROUND:   next = DONE;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_sig   <= '0;
            out_exp   <= '0;
            out_fb    <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                shreg <= in_mag;
                count <= '0;
            end
            if (state == SHIFT && !shift_done) begin
                shreg <= shreg << 1;
                count <= count + 1'b1;
            end
            if (state == ROUND) begin
                out_valid <= 1'b1;
                out_sig   <= rnd_sig;
                out_exp   <= rnd_exp;
                out_fb    <= fb;
                out_sat   <= sat;
            end
            if (state == DONE && out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lead_bits_normalizer.sv
// tb_lead_bits_normalizer: directed self-checking bench for lead_bits_normalizer.
module tb_lead_bits_normalizer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] in_mag = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_sig;
    logic [2:0]  out_exp;
    logic        out_fb;
    logic        out_sat;
    int vectors = 0;
    int miscompares = 0;

    lead_bits_normalizer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_mag   (in_mag),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sig  (out_sig),
        .out_exp  (out_exp),
        .out_fb   (out_fb),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one value in IDLE and counts clocks from the accept edge until
    // out_valid, giving up after 40 clocks.
    task automatic send(input logic [10:0] m, output int lat);
        in_mag   = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, out_sig, out_exp, out_fb, out_sat, in_ready} !== 11'b0_0000_000_0_0_1) begin
            miscompares++;
            $display("FAIL reset: got valid=%b sig=%b exp=%b fb=%b sat=%b ready=%b, want 0 0000 000 0 0 1",
                     out_valid, out_sig, out_exp, out_fb, out_sat, in_ready);
        end
    endtask

    typedef struct {
        logic [10:0] mag;
        logic [8:0]  res;
        int          lat;
    } vec_t;

    task automatic test_normalize();
        vec_t tbl[11];
        int lat;
        tbl[0]  = '{11'b00000101111, 9'b1100_010_1_0, 7};
        tbl[1]  = '{11'b01101000101, 9'b1101_110_0_0, 3};
        tbl[2]  = '{11'b00011111000, 9'b1000_101_1_0, 5};
        tbl[3]  = '{11'b11111111111, 9'b1111_111_1_1, 2};
        tbl[4]  = '{11'b00000000000, 9'b0000_000_0_0, 9};
        tbl[5]  = '{11'b00000000101, 9'b0101_000_0_0, 9};
        tbl[6]  = '{11'b00001111111, 9'b1000_100_1_0, 6};
        tbl[7]  = '{11'b10000000000, 9'b1000_111_0_0, 2};
        tbl[8]  = '{11'b11110111111, 9'b1111_111_0_0, 2};
        tbl[9]  = '{11'b00000010111, 9'b1100_001_1_0, 8};
        tbl[10] = '{11'b00000001111, 9'b1111_000_0_0, 9};
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].mag, lat);
            vectors++;
            if (lat !== tbl[i].lat) begin
                miscompares++;
                $display("FAIL latency[%0d] mag=%b: got %0d, want %0d", i, tbl[i].mag, lat, tbl[i].lat);
            end
            vectors++;
            if ({out_sig, out_exp, out_fb, out_sat} !== tbl[i].res) begin
                miscompares++;
                $display("FAIL result[%0d] mag=%b: got sig/exp/fb/sat=%b, want %b",
                         i, tbl[i].mag, {out_sig, out_exp, out_fb, out_sat}, tbl[i].res);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send(11'b00011111000, lat);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d, want 5", lat);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_mag   = 11'h7FF;
            @(posedge clk); #1;
            vectors++;
            if ({out_valid, in_ready, out_sig, out_exp, out_fb, out_sat} !== 11'b1_0_1000_101_1_0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got valid/ready/sig/exp/fb/sat=%b, want 10100010110",
                         i, {out_valid, in_ready, out_sig, out_exp, out_fb, out_sat});
            end
        end
        in_valid = 1'b0;
        release_out();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b, want 1", in_ready);
        end
        send(11'b01101000101, lat);
        vectors++;
        if (lat !== 3 || {out_sig, out_exp, out_fb, out_sat} !== 9'b1101_110_0_0) begin
            miscompares++;
            $display("FAIL b2b_result: got lat=%0d sig/exp/fb/sat=%b, want 3 110111000",
                     lat, {out_sig, out_exp, out_fb, out_sat});
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        release_out();
        in_mag   = 11'b00000101111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, out_sig, out_exp, out_fb, out_sat, in_ready} !== 11'b0_0000_000_0_0_1) begin
            miscompares++;
            $display("FAIL mid_reset: got valid=%b sig=%b exp=%b fb=%b sat=%b ready=%b, want 0 0000 000 0 0 1",
                     out_valid, out_sig, out_exp, out_fb, out_sat, in_ready);
        end
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_reset_discard: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        send(11'b00000101111, lat);
        vectors++;
        if (lat !== 7 || {out_sig, out_exp, out_fb, out_sat} !== 9'b1100_010_1_0) begin
            miscompares++;
            $display("FAIL mid_reset_fresh: got lat=%0d sig/exp/fb/sat=%b, want 7 110001010",
                     lat, {out_sig, out_exp, out_fb, out_sat});
        end
        release_out();
    endtask

    initial begin
        test_reset();
        test_normalize();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
